// File: rtl/tape_defs.sv
// -----------------------------------------------------------------------------
// tape_defs
// Constants and types shared by the paper-tape decoding path and the
// top-level controller.
//
// Contents:
//   NOTE_START    - byte that opens a note on the tape
//   NOTE_END      - end-of-song marker; the decoder locks out after it
//   ROWS_PER_BYTE - 2-bit rows that make up one byte
//   LAST_ROW      - row_cnt value while the final row of a byte is pending
//   dec_state_t   - decoder state encoding
//   shift_in_row  - shift one row into the low end of the byte accumulator
// -----------------------------------------------------------------------------
package tape_defs;

    localparam logic [7:0] NOTE_START    = 8'h00;
    localparam logic [7:0] NOTE_END      = 8'hFF;
    localparam int         ROWS_PER_BYTE = 4;

    // row_cnt holds the number of rows already collected, so the final row
    // arrives while the counter still reads ROWS_PER_BYTE-1.
    localparam logic [1:0] LAST_ROW = 2'(ROWS_PER_BYTE - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ASSEMBLE = 2'd1,
        DONE     = 2'd2
    } dec_state_t;

    // Left shift: the first row of a byte ends up in bits [7:6] after all
    // four rows have been shifted in (MSB first).
    function automatic logic [7:0] shift_in_row(input logic [7:0] acc,
                                                input logic [1:0] row);
        return {acc[5:0], row};
    endfunction

endpackage

// File: rtl/tape_strobe_edge.sv
// -----------------------------------------------------------------------------
// tape_strobe_edge
// Rising-edge detector for the sprocket (row strobe) track of the tape.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous, active-high reset
//   strobe     in   debounced strobe sensor level
//   edge_pulse out  one-cycle pulse on a low-to-high strobe transition
//
// The registered copy resets to 1 so that a strobe already high when reset
// releases is not mistaken for a new row; a real low-to-high transition is
// required before the first row is taken.
// -----------------------------------------------------------------------------
module tape_strobe_edge (
    input  logic clk,
    input  logic rst,
    input  logic strobe,
    output logic edge_pulse
);

    logic strobe_q;

    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // the values from before the clock edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            strobe_q <= 1'b1;
        end else begin
            strobe_q <= strobe;
        end
    end

    // Combinational on purpose: the row bits are sampled in this same cycle,
    // so the pulse must line up with the sensor inputs, not lag by one.
    assign edge_pulse = strobe & ~strobe_q;

endmodule

// File: rtl/tape_byte_decoder.sv
// -----------------------------------------------------------------------------
// tape_byte_decoder
// Assembles 2-bit rows read from the paper tape into 8-bit note bytes.
// Each strobe rising edge contributes one row (MSB-first); after four rows
// the byte is latched on data_out and announced with a one-cycle flush.
// A partial byte that stalls for ROW_TIMEOUT clocks is dropped with a
// frame_err pulse. Once the end-of-song byte (NOTE_END) has been emitted
// the decoder ignores the tape until reset.
//
// Parameters:
//   ROW_TIMEOUT  clocks allowed between strobes inside a byte
//   TO_W         timeout counter width, 2**TO_W must exceed ROW_TIMEOUT
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous, active-high reset
//   rl_signal  in   [2] row strobe, [1:0] row data bits (debounced)
//   data_out   out  last completed byte, held until the next flush
//   flush      out  one-cycle pulse, data_out is new from this cycle
//   frame_err  out  one-cycle pulse, a partial byte was discarded
//   end_seen   out  level, NOTE_END has been emitted
//   row_cnt    out  rows collected in the byte currently being built
// -----------------------------------------------------------------------------
module tape_byte_decoder
    import tape_defs::*;
#(
    parameter int ROW_TIMEOUT = 100_000_000,
    parameter int TO_W        = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] rl_signal,
    output logic [7:0] data_out,
    output logic       flush,
    output logic       frame_err,
    output logic       end_seen,
    output logic [1:0] row_cnt
);

    // Counter value at which a stalled byte is abandoned.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ROW_TIMEOUT - 1);

    dec_state_t      state;
    dec_state_t      next_state;

    logic            row_edge;
    logic [1:0]      row;
    logic [7:0]      shift_q;
    logic [7:0]      next_byte;
    logic [TO_W-1:0] to_cnt;

    // Control strobes produced by the next-state logic for the datapath.
    logic            accept_row;
    logic            byte_done;
    logic            timeout_hit;

    // -------------------------------------------------------------------------
    // Strobe edge detection
    // -------------------------------------------------------------------------
    tape_strobe_edge u_strobe_edge (
        .clk        (clk),
        .rst        (rst),
        .strobe     (rl_signal[2]),
        .edge_pulse (row_edge)
    );

    // Row bits are taken in the same cycle as the edge.
    assign row       = rl_signal[1:0];
    assign next_byte = shift_in_row(shift_q, row);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // An edge always takes priority over the timeout, so a row arriving on
    // the very last allowed cycle is still accepted.
    // -------------------------------------------------------------------------
    // NOTE: every signal assigned here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        next_state  = state;
        accept_row  = 1'b0;
        byte_done   = 1'b0;
        timeout_hit = 1'b0;

        unique case (state)
            IDLE: begin
                // No timeout here: the gap between bytes is unbounded.
                if (row_edge) begin
                    accept_row = 1'b1;
                    next_state = ASSEMBLE;
                end
            end

            ASSEMBLE: begin
                if (row_edge) begin
                    accept_row = 1'b1;
                    if (row_cnt == LAST_ROW) begin
                        byte_done  = 1'b1;
                        next_state = (next_byte == NOTE_END) ? DONE : IDLE;
                    end
                end else if (to_cnt == TO_LAST) begin
                    timeout_hit = 1'b1;
                    next_state  = IDLE;
                end
            end

            DONE: begin
                // End of song: the tape is ignored until reset.
                next_state = DONE;
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: shift register, row counter, timeout counter, output byte
    // flush and frame_err follow byte_done/timeout_hit by one cycle; the two
    // are mutually exclusive because an edge suppresses the timeout, and a
    // byte can only complete or time out from ASSEMBLE, which is left at once.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the shift register is cleared on reset even though four
            // shifts always overwrite it, so a dropped partial byte never
            // leaks into the next one through a debug view.
            shift_q   <= '0;
            row_cnt   <= '0;
            to_cnt    <= '0;
            data_out  <= NOTE_START;
            flush     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            flush     <= byte_done;
            frame_err <= timeout_hit;

            if (accept_row) begin
                to_cnt <= '0;
                if (byte_done) begin
                    data_out <= next_byte;
                    shift_q  <= '0;
                    row_cnt  <= '0;
                end else begin
                    shift_q <= next_byte;
                    row_cnt <= row_cnt + 2'd1;
                end
            end else if (timeout_hit) begin
                // Partial byte is discarded; data_out keeps the last good byte.
                shift_q <= '0;
                row_cnt <= '0;
                to_cnt  <= '0;
            end else if (state == ASSEMBLE) begin
                to_cnt <= to_cnt + TO_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output logic
    // -------------------------------------------------------------------------
    always_comb begin
        end_seen = (state == DONE);
    end

endmodule

// File: tb/tb_tape_byte_decoder.sv
// -----------------------------------------------------------------------------
// tb_tape_byte_decoder
// Directed bench for tape_byte_decoder with a short row timeout (20 clocks).
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_tape_byte_decoder;

    localparam int RT = 20;

    logic       clk;
    logic       rst;
    logic [2:0] rl_signal;
    logic [7:0] data_out;
    logic       flush;
    logic       frame_err;
    logic       end_seen;
    logic [1:0] row_cnt;

    int errors = 0;
    int checks = 0;

    // Pulse monitor state
    int   flush_cnt = 0;
    int   ferr_cnt  = 0;
    int   viol_cnt  = 0;
    logic prev_flush = 1'b0;
    logic prev_ferr  = 1'b0;

    typedef struct {
        string      name;
        logic [7:0] rows;      // four 2-bit rows, first row in [7:6]
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[5];

    tape_byte_decoder #(
        .ROW_TIMEOUT (RT),
        .TO_W        (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rl_signal (rl_signal),
        .data_out  (data_out),
        .flush     (flush),
        .frame_err (frame_err),
        .end_seen  (end_seen),
        .row_cnt   (row_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count pulses and protocol violations shortly after each rising edge.
    always @(posedge clk) begin
        #2;
        if (flush === 1'b1) flush_cnt++;
        if (frame_err === 1'b1) ferr_cnt++;
        if (flush === 1'b1 && frame_err === 1'b1) viol_cnt++;
        if (flush === 1'b1 && prev_flush === 1'b1) viol_cnt++;
        if (frame_err === 1'b1 && prev_ferr === 1'b1) viol_cnt++;
        prev_flush = flush;
        prev_ferr  = frame_err;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    // One strobe: high for a cycle (edge), then low for a cycle.
    // Returns the outputs seen right after the edge cycle.
    task automatic strobe_row(input logic [1:0] row, output logic [1:0] rc,
                              output logic fl, output logic fe);
        rl_signal = {1'b1, row};
        tick();
        rc = row_cnt;
        fl = flush;
        fe = frame_err;
        rl_signal = 3'b000;
        tick();
    endtask

    task automatic send_byte(input logic [7:0] rows, input logic [7:0] exp_data,
                             input string tag);
        logic [1:0] rc;
        logic       fl;
        logic       fe;
        for (int j = 0; j < 4; j++) begin
            strobe_row(rows[7-2*j -: 2], rc, fl, fe);
            check($sformatf("%s_cnt%0d", tag, j), rc, (j == 3) ? 0 : j + 1);
            check($sformatf("%s_flush%0d", tag, j), fl, (j == 3) ? 1 : 0);
        end
        check($sformatf("%s_data", tag), data_out, exp_data);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick();
    endtask

    initial begin
        logic [1:0] rc;
        logic       fl;
        logic       fe;
        int         fl_before;
        int         fe_before;

        vecs[0] = '{"b9c", 8'b10_01_11_00, 8'h9C};
        vecs[1] = '{"b66", 8'b01_10_01_10, 8'h66};
        vecs[2] = '{"b00", 8'b00_00_00_00, 8'h00};
        vecs[3] = '{"bfe", 8'b11_11_11_10, 8'hFE};
        vecs[4] = '{"b72", 8'b01_11_00_10, 8'h72};

        rst       = 1'b1;
        rl_signal = 3'b000;
        tick(2);

        // Reset state
        check("rst_data", data_out, 8'h00);
        check("rst_flush", flush, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_end", end_seen, 0);
        check("rst_cnt", row_cnt, 0);
        rst = 1'b0;
        tick();

        // Table-driven bytes
        for (int i = 0; i < 5; i++) begin
            send_byte(vecs[i].rows, vecs[i].exp_data, vecs[i].name);
            check($sformatf("%s_end", vecs[i].name), end_seen, 0);
        end
        check("table_flushes", flush_cnt, 5);

        // Timeout after two rows
        strobe_row(2'b11, rc, fl, fe);
        strobe_row(2'b01, rc, fl, fe);
        check("to_cnt2", rc, 2);
        tick(18);
        check("to_ferr_early", frame_err, 0);
        check("to_cnt_early", row_cnt, 2);
        tick();
        check("to_ferr", frame_err, 1);
        check("to_cnt_zero", row_cnt, 0);
        check("to_data_kept", data_out, 8'h72);
        tick();
        check("to_ferr_one_cycle", frame_err, 0);
        send_byte(8'b00_00_00_01, 8'h01, "after_to");
        check("to_ferr_count", ferr_cnt, 1);

        // Third edge exactly on the last allowed cycle: edge wins
        strobe_row(2'b10, rc, fl, fe);
        strobe_row(2'b10, rc, fl, fe);
        tick(18);
        rl_signal = 3'b111;
        tick();
        check("race_ferr", frame_err, 0);
        check("race_cnt", row_cnt, 3);
        rl_signal = 3'b000;
        tick();
        strobe_row(2'b01, rc, fl, fe);
        check("race_flush", fl, 1);
        check("race_data", data_out, 8'hAD);
        check("race_ferr_count", ferr_cnt, 1);

        // Reset in the middle of a byte
        strobe_row(2'b11, rc, fl, fe);
        strobe_row(2'b00, rc, fl, fe);
        strobe_row(2'b10, rc, fl, fe);
        check("mid_cnt3", rc, 3);
        fl_before = flush_cnt;
        fe_before = ferr_cnt;
        rst = 1'b1;
        tick();
        check("mid_data_cleared", data_out, 8'h00);
        check("mid_cnt_cleared", row_cnt, 0);
        rst = 1'b0;
        tick(3);
        check("mid_no_flush", flush_cnt, fl_before);
        check("mid_no_ferr", ferr_cnt, fe_before);
        send_byte(8'b01_10_01_10, 8'h66, "mid_fresh");

        // Strobe held high through reset release
        rl_signal = 3'b100;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        fl_before = flush_cnt;
        tick(50);
        check("hold_cnt", row_cnt, 0);
        check("hold_no_flush", flush_cnt, fl_before);
        rl_signal = 3'b000;
        tick();
        rl_signal = 3'b100;
        tick();
        check("hold_first_row", row_cnt, 1);
        tick(10);
        check("hold_one_edge", row_cnt, 1);
        rl_signal = 3'b000;
        tick();
        strobe_row(2'b11, rc, fl, fe);
        strobe_row(2'b11, rc, fl, fe);
        strobe_row(2'b11, rc, fl, fe);
        check("hold_flush", fl, 1);
        check("hold_data", data_out, 8'h3F);

        // End-of-song lockout
        send_byte(8'b11_11_11_11, 8'hFF, "end");
        check("end_seen", end_seen, 1);
        fl_before = flush_cnt;
        fe_before = ferr_cnt;
        for (int j = 0; j < 4; j++) begin
            strobe_row(2'b01, rc, fl, fe);
            check($sformatf("lock_cnt%0d", j), rc, 0);
        end
        tick(30);
        check("lock_no_flush", flush_cnt, fl_before);
        check("lock_no_ferr", ferr_cnt, fe_before);
        check("lock_data", data_out, 8'hFF);
        check("lock_end", end_seen, 1);
        do_reset();
        check("lock_rst_end", end_seen, 0);
        check("lock_rst_data", data_out, 8'h00);

        check("pulse_protocol", viol_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tape_byte_decoder.md
# tape_byte_decoder

Decodes the three debounced reflective-light sensor channels of the paper tape into 8-bit note bytes for the recording path. It sits between the per-channel sensor debouncers and the memory write logic of the top-level controller. Each completed byte is held stable on `data_out` and announced by a one-cycle `flush` pulse. It also provides a partial-byte timeout and a lockout after the end-of-song marker.

## Interface
Parameters:
- `ROW_TIMEOUT`, default 100_000_000: clocks allowed between strobes inside a byte (1 s at 100 MHz).
- `TO_W`, default 27: timeout counter width; must satisfy 2^TO_W > ROW_TIMEOUT.

Ports (one clock domain; reset is synchronous and active-high):
- `clk` input 1: system clock.
- `rst` input 1: synchronous, active-high reset.
- `rl_signal` input 3: debounced sensors. [2] is the row strobe (sprocket track); [1:0] are the row data bits.
- `data_out` output 8: last completed byte, held until the next flush.
- `flush` output 1: one-cycle pulse; `data_out` is valid from this cycle onward.
- `frame_err` output 1: one-cycle pulse when a partial byte is discarded on timeout.
- `end_seen` output 1: level; high after 8'hFF has been emitted.
- `row_cnt` output 2: number of rows collected in the current byte (debug/LED).

## Operation
- Strobe edge: `edge` = `rl_signal[2]` & ~`strobe_q`. `strobe_q` is `rl_signal[2]` registered.
- Row sampling: on the `edge` cycle, row = {`rl_signal[1]`, `rl_signal[0]`}, taken from that same cycle.
- Bit order: the first row of a byte goes to bits [7:6], the second to [5:4], the third to [3:2], the fourth to [1:0] (MSB first). Assembly uses a left-shifting shift register.
- States:
  - IDLE: waiting for the first row. On `edge`: shift in the row, set `row_cnt`=1, clear the timeout counter, go to ASSEMBLE.
  - ASSEMBLE: each `edge` shifts in a row and increments `row_cnt`.
    - On the 4th edge: latch the full byte to `data_out`, assert `flush`, set `row_cnt`=0. Go to DONE if the byte is 8'hFF, otherwise to IDLE.
    - The timeout counter increments every cycle without an edge. When it reaches ROW_TIMEOUT-1: discard the shift register, set `row_cnt`=0, pulse `frame_err`, go to IDLE. `data_out` is unchanged.
  - DONE: `end_seen`=1; all strobes are ignored; no flush and no frame_err. Only `rst` exits this state, to IDLE.
- There is no timeout in IDLE. Gaps between bytes are unbounded.
- 8'h00 (note start) is a normal byte and is flushed like any other.

## Timing
- Reset values: `data_out`=8'h00, `flush`=0, `frame_err`=0, `end_seen`=0, `row_cnt`=0, state IDLE, timeout counter 0.
- `strobe_q` resets to 1. A strobe that is already high when reset releases is not an edge; the first edge requires a low-to-high transition after reset.
- Latency: 4th strobe edge in cycle t causes `flush`=1 and the new `data_out` in cycle t+1. `end_seen` rises in t+1 if the byte is 8'hFF.
- `flush` and `frame_err` are never high in the same cycle. Neither is ever high for two consecutive cycles.
- Edge and timeout in the same cycle: the edge wins. The row is accepted and the counter is cleared.
- `rst` mid-byte: the partial byte is dropped silently (no `frame_err`), and `data_out` returns to 8'h00 in the next cycle.
- A strobe held high for many cycles produces one edge only.
- The consumer may sample `data_out` in any cycle. It changes only in flush cycles and on reset.

## Structure
- Shared package/include `tape_defs`: NOTE_START=8'h00, NOTE_END=8'hFF, ROWS_PER_BYTE=4, and the state encodings (IDLE=2'd0, ASSEMBLE=2'd1, DONE=2'd2). The top-level controller uses the same NOTE_END.
- One sub-module, `tape_strobe_edge`: registers the strobe, reset value 1, and outputs the `edge` pulse. The FSM, shift register and timeout counter stay in `tape_byte_decoder`.

## Test plan
- Reset, then four strobes with rows 10,01,11,00 → `data_out`=8'h9C and a single `flush` one cycle after the 4th edge; `row_cnt` goes 1,2,3,0.
- Rows 11,11,11,11 → `data_out`=8'hFF and `end_seen`=1. Then four strobes with rows 01 each → no flush, and `data_out` stays 8'hFF. Assert `rst` → `end_seen`=0 and `data_out`=8'h00.
- ROW_TIMEOUT=20: two rows, then no strobe for 20 cycles → one `frame_err` pulse, `row_cnt`=0, `data_out` unchanged. The next four rows 00,00,00,01 → 8'h01 flushed.
- ROW_TIMEOUT=20: the 3rd edge lands exactly on the cycle the counter hits 19 → no `frame_err`. After the 4th row, the byte is flushed correctly.
- Strobe high during reset release, then held for 50 cycles → no row captured. Low-to-high afterwards → `row_cnt`=1.
- `rst` asserted after 3 rows of a byte → no flush and no `frame_err`. Four fresh rows 01,10,01,10 → 8'h66.
